regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised 2-read/1-write general-purpose register file with a per-register busy scoreboard.
//  Sits in the decode stage of the pipelined CPU: ID reads operands, WB writes results.
//  The scoreboard tracks in-flight destinations so the hazard unit can stall on RAW.
//  Register 0 reads as zero when HARD_ZERO=1.
// PARAMETERS
//  DATA_W     32  register width in bits
//  ADDR_W     5   address width; depth = 2**ADDR_W
//  HARD_ZERO  1   1: reg 0 ignores writes, reads 0, never busy; 0: reg 0 is ordinary
// PORTS
//  Clk        in   1       clock; all state updates on posedge
//  Reset_n    in   1       asynchronous active-low reset
//  readReg1   in   ADDR_W  read port 1 address
//  readReg2   in   ADDR_W  read port 2 address
//  readData1  out  DATA_W  read port 1 data (combinational)
//  readData2  out  DATA_W  read port 2 data (combinational)
//  regWrite   in   1       write enable (WB)
//  writeReg   in   ADDR_W  write address
//  writeData  in   DATA_W  write data
//  issueValid in   1       instruction with a destination issues this cycle
//  issueReg   in   ADDR_W  destination being marked busy
//  busy1      out  1       readReg1 has a pending write (combinational)
//  busy2      out  1       readReg2 has a pending write (combinational)
//  busyVec    out  2**ADDR_W  raw scoreboard bits, bit i = reg i
// BEHAVIOUR
//  - Reset (Reset_n=0, async): every register = 0, every busy bit = 0; readData*=0, busy*=0, busyVec=0.
//    Writes and issues are ignored while Reset_n=0. Reset mid-pending write discards the pending state.
//  - Write: on posedge Clk with regWrite=1, reg[writeReg] <= writeData and busy[writeReg] <= 0.
//  - Issue: on posedge Clk with issueValid=1, busy[issueReg] <= 1.
//  - Same reg issued and written in the same cycle: data written AND busy ends 1 (set wins over clear).
//  - Same reg issued twice before writeback: single busy bit; the first write clears it (no counting).
//  - Reads: readDataN = reg[readRegN] (no clock latency); busyN = busy[readRegN].
//  - HARD_ZERO=1: writes to reg 0 dropped; issue to reg 0 ignored; readData=0 and busy=0 for address 0.
//  - Address arithmetic unsigned, full ADDR_W range valid; no out-of-range case.
//  - Write-data width exactly DATA_W; no sign/zero extension inside the block.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - Write-through bypass: if regWrite=1 and writeReg==readRegN (and not hard reg 0), readDataN = writeData
//     in the same cycle, and busyN = 0 for that port unless issueValid targets the same reg.
//  REGFILE_BYPASS_EN undefined:
//   - readDataN returns the stored value; new data visible the cycle after the write edge.
//   - busyN reflects the stored busy bit only.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert Reset_n=0 between edges -> readData1(r5)=0 immediately, busyVec=0.
//  2 Write/read: write r7=0x12345678, next cycle readReg1=7,readReg2=7 -> both data 0x12345678, busy1=busy2=0.
//  3 Hard zero: write r0=0xFFFFFFFF and issue r0 -> readData1(r0)=0, busy1=0, busyVec[0]=0.
//  4 Scoreboard: issue r3 -> busyVec[3]=1 next cycle; write r3=0xA5 -> busyVec[3]=0 after edge.
//  5 Collision: issue r4 and write r4=0x55 same edge -> r4=0x55, busyVec[4]=1.
//  6 Bypass: regWrite r9=0xCAFE, readReg2=9 same cycle -> readData2=0xCAFE, busy2=0 with REGFILE_BYPASS_EN;
//    old value, busy2 = stored bit without it.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register busy scoreboard for RAW stall detection.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) onto the read ports.
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit HARD_ZERO = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [ADDR_W-1:0]      readReg1,
  input  logic [ADDR_W-1:0]      readReg2,
  output logic [DATA_W-1:0]      readData1,
  output logic [DATA_W-1:0]      readData2,
  input  logic                   regWrite,
  input  logic [ADDR_W-1:0]      writeReg,
  input  logic [DATA_W-1:0]      writeData,
  input  logic                   issueValid,
  input  logic [ADDR_W-1:0]      issueReg,
  output logic                   busy1,
  output logic                   busy2,
  output logic [(2**ADDR_W)-1:0] busyVec
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] cellData [DEPTH];
  logic [DEPTH-1:0]  cellBusy;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gCell
      if (HARD_ZERO && gi == 0) begin : gZero
        // Hardwired zero register: no storage, never busy.
        assign cellData[gi] = '0;
        assign cellBusy[gi] = 1'b0;
      end else begin : gStore
        logic [DATA_W-1:0] dataReg;
        logic              busyReg;
        logic              writeHit;
        logic              issueHit;

        assign writeHit = regWrite   && (writeReg == ADDR_W'(gi));
        assign issueHit = issueValid && (issueReg == ADDR_W'(gi));

        always_ff @(posedge Clk or negedge Reset_n) begin
          if (!Reset_n) begin
            dataReg <= '0;
            busyReg <= 1'b0;
          end else begin
            if (writeHit) begin
              dataReg <= writeData;
            end
            // A new issue to the same register outranks its writeback clearing busy.
            if (issueHit) begin
              busyReg <= 1'b1;
            end else if (writeHit) begin
              busyReg <= 1'b0;
            end
          end
        end

        assign cellData[gi] = dataReg;
        assign cellBusy[gi] = busyReg;
      end
    end
  endgenerate

  assign busyVec = cellBusy;

  logic [DATA_W-1:0] storedData1;
  logic [DATA_W-1:0] storedData2;
  logic              storedBusy1;
  logic              storedBusy2;

  assign storedData1 = cellData[readReg1];
  assign storedData2 = cellData[readReg2];
  assign storedBusy1 = cellBusy[readReg1];
  assign storedBusy2 = cellBusy[readReg2];

`ifdef REGFILE_BYPASS_EN
  logic writeable1;
  logic writeable2;
  logic bypass1;
  logic bypass2;
  logic reissue1;
  logic reissue2;

  assign writeable1 = !(HARD_ZERO && readReg1 == '0);
  assign writeable2 = !(HARD_ZERO && readReg2 == '0);
  assign bypass1    = regWrite && (writeReg == readReg1) && writeable1;
  assign bypass2    = regWrite && (writeReg == readReg2) && writeable2;
  // A same-cycle issue to the forwarded register keeps the port reporting busy.
  assign reissue1   = issueValid && (issueReg == readReg1);
  assign reissue2   = issueValid && (issueReg == readReg2);

  assign readData1 = bypass1 ? writeData : storedData1;
  assign readData2 = bypass2 ? writeData : storedData2;
  assign busy1     = bypass1 ? reissue1 : storedBusy1;
  assign busy2     = bypass2 ? reissue2 : storedBusy2;
`else
  assign readData1 = storedData1;
  assign readData2 = storedData2;
  assign busy1     = storedBusy1;
  assign busy2     = storedBusy2;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                   Clk;
  logic                   Reset_n;
  logic [ADDR_W-1:0]      readReg1;
  logic [ADDR_W-1:0]      readReg2;
  logic [DATA_W-1:0]      readData1;
  logic [DATA_W-1:0]      readData2;
  logic                   regWrite;
  logic [ADDR_W-1:0]      writeReg;
  logic [DATA_W-1:0]      writeData;
  logic                   issueValid;
  logic [ADDR_W-1:0]      issueReg;
  logic                   busy1;
  logic                   busy2;
  logic [(2**ADDR_W)-1:0] busyVec;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARD_ZERO(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .issueValid(issueValid), .issueReg(issueReg),
    .busy1(busy1), .busy2(busy2), .busyVec(busyVec)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    regWrite   = 1'b0;
    issueValid = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; readReg1 = '0; readReg2 = '0;
    regWrite = 1'b0; writeReg = '0; writeData = '0;
    issueValid = 1'b0; issueReg = '0;
    tick(); tick();
    check("reset_data1", 64'(readData1), 64'h0);
    check("reset_busyvec", 64'(busyVec), 64'h0);
    check("reset_busy1", 64'(busy1), 64'h0);
    Reset_n = 1'b1;

    // 1: populate r5 and busy r6, then async reset between edges
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    issueValid = 1'b1; issueReg = 5'd6;
    tick(); idle();
    readReg1 = 5'd5;
    #1;
    check("pre_reset_r5", 64'(readData1), 64'hDEADBEEF);
    check("pre_reset_busyvec", 64'(busyVec), 64'h40);
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_r5", 64'(readData1), 64'h0);
    check("async_reset_busyvec", 64'(busyVec), 64'h0);
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h11111111;
    issueValid = 1'b1; issueReg = 5'd5;
    tick(); idle();
    check("write_in_reset_r5", 64'(readData1), 64'h0);
    check("issue_in_reset", 64'(busyVec), 64'h0);
    Reset_n = 1'b1;

    // 2: write then read on both ports
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h12345678;
    tick(); idle();
    readReg1 = 5'd7; readReg2 = 5'd7;
    #1;
    check("r7_port1", 64'(readData1), 64'h12345678);
    check("r7_port2", 64'(readData2), 64'h12345678);
    check("r7_busy1", 64'(busy1), 64'h0);
    check("r7_busy2", 64'(busy2), 64'h0);

    // 3: hard-zero register
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    issueValid = 1'b1; issueReg = 5'd0;
    tick(); idle();
    readReg1 = 5'd0;
    #1;
    check("r0_data", 64'(readData1), 64'h0);
    check("r0_busy1", 64'(busy1), 64'h0);
    check("r0_busyvec", 64'(busyVec), 64'h0);

    // 4: scoreboard set, double issue, single clear
    issueValid = 1'b1; issueReg = 5'd3;
    tick(); idle();
    readReg1 = 5'd3;
    #1;
    check("r3_busyvec_set", 64'(busyVec), 64'h8);
    check("r3_busy1_set", 64'(busy1), 64'h1);
    issueValid = 1'b1; issueReg = 5'd3;
    tick(); idle();
    check("r3_reissue", 64'(busyVec), 64'h8);
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5;
    tick(); idle();
    check("r3_busyvec_clr", 64'(busyVec), 64'h0);
    check("r3_busy1_clr", 64'(busy1), 64'h0);
    check("r3_data", 64'(readData1), 64'hA5);

    // 5: issue and write the same register on one edge
    regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h55;
    issueValid = 1'b1; issueReg = 5'd4;
    tick(); idle();
    readReg2 = 5'd4;
    #1;
    check("r4_data", 64'(readData2), 64'h55);
    check("r4_busyvec", 64'(busyVec), 64'h10);
    check("r4_busy2", 64'(busy2), 64'h1);
    regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h66;
    tick(); idle();
    check("r4_clear", 64'(busyVec), 64'h0);

    // Top address boundary
    regWrite = 1'b1; writeReg = 5'd31; writeData = 32'hA0A0A0A0;
    issueValid = 1'b1; issueReg = 5'd31;
    tick(); idle();
    readReg1 = 5'd31;
    #1;
    check("r31_data", 64'(readData1), 64'hA0A0A0A0);
    check("r31_busyvec", 64'(busyVec), 64'h80000000);
    regWrite = 1'b1; writeReg = 5'd31; writeData = 32'h0;
    tick(); idle();

    // 6: same-cycle write vs read (r9 holds 0x1111 and is busy beforehand)
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h1111;
    issueValid = 1'b1; issueReg = 5'd9;
    tick(); idle();
    readReg2 = 5'd9;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hCAFE;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_data2", 64'(readData2), 64'hCAFE);
    check("bypass_busy2", 64'(busy2), 64'h0);
`else
    check("nobypass_data2", 64'(readData2), 64'h1111);
    check("nobypass_busy2", 64'(busy2), 64'h1);
`endif
    tick(); idle();
    check("r9_after_write", 64'(readData2), 64'hCAFE);
    check("r9_busy_after", 64'(busy2), 64'h0);
    check("final_busyvec", 64'(busyVec), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
